// File: rtl/yin_tau_picker.sv
// yin_tau_picker
// Picks one pitch period per analysis frame from the streamed YIN difference
// function d(tau). It applies the cumulative-mean-normalized threshold test
// d'(t) < THRESHOLD/256 without a divider, by cross-multiplying:
//   d(t) * t * 256 < THRESHOLD * S(t),   where S(t) = sum of d(1..t).
// Once a dip below threshold is found, the local minimum ends at the first
// rise. Unvoiced frames re-emit the last voiced tau.
//
// Ports:
//   clk_in         system clock
//   rst_in         asynchronous, active-high reset
//   diff_in        unsigned d(tau) for the current lag
//   diff_valid_in  diff_in qualifier (gaps allowed, no backpressure)
//   diff_last_in   final beat of a frame (sampled with diff_valid_in)
//   tau_out        chosen period in samples (held between pulses)
//   tau_valid_out  one-cycle pulse, exactly one per frame
//   voiced_out     1 = threshold crossing found, 0 = fallback tau
module yin_tau_picker #(
  parameter int MAX_TAU     = 2047,
  parameter int MIN_TAU     = 20,
  parameter int THRESHOLD   = 26,
  parameter int DEFAULT_TAU = 100,
  parameter int DATA_W      = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [DATA_W-1:0] diff_in,
  input  logic              diff_valid_in,
  input  logic              diff_last_in,
  output logic [10:0]       tau_out,
  output logic              tau_valid_out,
  output logic              voiced_out
);

  localparam int SUM_W  = DATA_W + 11;
  localparam int PROD_W = SUM_W + 8;

  localparam logic [11:0]       IDX_MAX = 12'(MAX_TAU);
  localparam logic [10:0]       TAU_MAX = 11'(MAX_TAU);
  localparam logic [10:0]       TAU_MIN = 11'(MIN_TAU);
  localparam logic [10:0]       TAU_DEF = 11'(DEFAULT_TAU);
  localparam logic [PROD_W-1:0] THR     = PROD_W'(THRESHOLD);

  typedef enum logic [1:0] {S_SEARCH, S_DIP, S_FLUSH} state_t;

  // Lag counter, running sum and previous raw beat
  logic [11:0]       r_idx;
  logic [SUM_W-1:0]  r_sum;
  logic [DATA_W-1:0] r_dprev;

  logic              w_inrng;
  logic [10:0]       w_idx;
  logic [SUM_W-1:0]  w_sum_nxt;

  // Beats past MAX_TAU report idx = MAX_TAU so a dip running off the end of
  // the examined range still emits a sensible period.
  assign w_inrng   = (r_idx <= IDX_MAX);
  assign w_idx     = w_inrng ? r_idx[10:0] : TAU_MAX;
  assign w_sum_nxt = r_sum + ((w_inrng && r_idx != 12'd0) ? SUM_W'(diff_in) : '0);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_idx <= '0;
      r_sum <= '0;
    end else if (diff_valid_in) begin
      if (diff_last_in) begin
        r_idx <= '0;
        r_sum <= '0;
      end else begin
        if (w_inrng) r_idx <= r_idx + 12'd1;
        r_sum <= w_sum_nxt;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (diff_valid_in) r_dprev <= diff_in;
  end

  // ---- stage 1: d*t, S(t), d, d_prev, idx, last ----
  logic              r_vld_p1;
  logic              r_last_p1;
  logic              r_inrng_p1;
  logic [SUM_W-1:0]  r_dt_p1;
  logic [SUM_W-1:0]  r_sum_p1;
  logic [DATA_W-1:0] r_d_p1;
  logic [DATA_W-1:0] r_dprev_p1;
  logic [10:0]       r_idx_p1;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_vld_p1   <= 1'b0;
      r_last_p1  <= 1'b0;
      r_inrng_p1 <= 1'b0;
    end else begin
      r_vld_p1   <= diff_valid_in;
      r_last_p1  <= diff_valid_in & diff_last_in;
      r_inrng_p1 <= w_inrng;
    end
  end

  always_ff @(posedge clk_in) begin
    if (diff_valid_in) begin
      r_dt_p1    <= SUM_W'(diff_in) * SUM_W'(w_idx);
      r_sum_p1   <= w_sum_nxt;
      r_d_p1     <= diff_in;
      r_dprev_p1 <= r_dprev;
      r_idx_p1   <= w_idx;
    end
  end

  logic [PROD_W-1:0] w_lhs;
  logic [PROD_W-1:0] w_rhs;
  logic              w_below;
  logic              w_rising;

  assign w_lhs    = {r_dt_p1, 8'd0};
  assign w_rhs    = THR * PROD_W'(r_sum_p1);
  assign w_below  = r_inrng_p1 && (r_idx_p1 >= TAU_MIN) &&
                    (r_sum_p1 != '0) && (w_lhs < w_rhs);
  assign w_rising = r_inrng_p1 && (r_idx_p1 != 11'd0) && (r_d_p1 > r_dprev_p1);

  // ---- stage 2: below / rising / idx / last ----
  logic        r_vld_p2;
  logic        r_last_p2;
  logic        r_below_p2;
  logic        r_rising_p2;
  logic [10:0] r_idx_p2;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_vld_p2    <= 1'b0;
      r_last_p2   <= 1'b0;
      r_below_p2  <= 1'b0;
      r_rising_p2 <= 1'b0;
    end else begin
      r_vld_p2    <= r_vld_p1;
      r_last_p2   <= r_last_p1;
      r_below_p2  <= w_below;
      r_rising_p2 <= w_rising;
    end
  end

  always_ff @(posedge clk_in) begin
    if (r_vld_p1) r_idx_p2 <= r_idx_p1;
  end

  // ---- FSM on stage 2 ----
  state_t      r_state;
  state_t      w_state_nxt;
  logic [10:0] r_tau_hold;
  logic        w_emit;
  logic [10:0] w_emit_tau;
  logic        w_emit_voiced;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= S_SEARCH;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_emit        = 1'b0;
    w_emit_tau    = r_tau_hold;
    w_emit_voiced = 1'b0;
    if (r_vld_p2) begin
      case (r_state)
        S_SEARCH: begin
          if (r_below_p2) begin
            if (r_last_p2) begin
              // Crossing on the final beat: that lag is the answer.
              w_emit        = 1'b1;
              w_emit_tau    = r_idx_p2;
              w_emit_voiced = 1'b1;
            end else begin
              w_state_nxt = S_DIP;
            end
          end else if (r_last_p2) begin
            w_emit = 1'b1;
          end
        end
        S_DIP: begin
          if (r_rising_p2) begin
            // Previous lag was the local minimum.
            w_emit        = 1'b1;
            w_emit_tau    = r_idx_p2 - 11'd1;
            w_emit_voiced = 1'b1;
            w_state_nxt   = r_last_p2 ? S_SEARCH : S_FLUSH;
          end else if (r_last_p2) begin
            w_emit        = 1'b1;
            w_emit_tau    = r_idx_p2;
            w_emit_voiced = 1'b1;
            w_state_nxt   = S_SEARCH;
          end
        end
        S_FLUSH: begin
          if (r_last_p2) w_state_nxt = S_SEARCH;
        end
        default: w_state_nxt = S_SEARCH;
      endcase
    end
  end

  // ---- output registers ----
  logic [10:0] r_tau_out;
  logic        r_tau_valid;
  logic        r_voiced;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_tau_hold  <= TAU_DEF;
      r_tau_out   <= TAU_DEF;
      r_tau_valid <= 1'b0;
      r_voiced    <= 1'b0;
    end else begin
      r_tau_valid <= w_emit;
      if (w_emit) begin
        r_tau_out <= w_emit_tau;
        r_voiced  <= w_emit_voiced;
        if (w_emit_voiced) r_tau_hold <= w_emit_tau;
      end
    end
  end

  assign tau_out       = r_tau_out;
  assign tau_valid_out = r_tau_valid;
  assign voiced_out    = r_voiced;

endmodule

// File: tb/tb_yin_tau_picker.sv
// Testbench for yin_tau_picker: frames are described as arrays of d(tau); a
// frame-level reference model finds the expected period and the beat that
// produces it, pushes it to a scoreboard, and a monitor checks every pulse.
module tb_yin_tau_picker;

  localparam int MAX_TAU     = 2047;
  localparam int MIN_TAU     = 20;
  localparam int THRESHOLD   = 26;
  localparam int DEFAULT_TAU = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] diff = '0;
  logic        dvalid = 1'b0;
  logic        dlast = 1'b0;
  logic [10:0] tau;
  logic        tau_valid;
  logic        voiced;

  yin_tau_picker #(
    .MAX_TAU(MAX_TAU), .MIN_TAU(MIN_TAU), .THRESHOLD(THRESHOLD),
    .DEFAULT_TAU(DEFAULT_TAU), .DATA_W(32)
  ) dut (
    .clk_in(clk), .rst_in(rst), .diff_in(diff), .diff_valid_in(dvalid),
    .diff_last_in(dlast), .tau_out(tau), .tau_valid_out(tau_valid),
    .voiced_out(voiced)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int tau; int voiced; int cyc; } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  logic [31:0] fr [0:2047];
  int m_hold = DEFAULT_TAU;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level reference: first lag >= MIN_TAU whose normalized difference
  // is below threshold, then the lag before the first subsequent increase.
  function automatic void model(input int n, output int etau, output int evoiced,
                                output int ebeat);
    longint s = 0;
    int t0 = -1;
    for (int t = 0; t < n; t++) begin
      if (t > 0) s += longint'(fr[t]);
      if (t >= MIN_TAU && s != 0 &&
          longint'(fr[t]) * t * 256 < longint'(THRESHOLD) * s) begin
        t0 = t;
        break;
      end
    end
    if (t0 < 0) begin
      etau = m_hold; evoiced = 0; ebeat = n - 1;
      return;
    end
    evoiced = 1;
    etau = n - 1;
    ebeat = n - 1;
    for (int t = t0 + 1; t < n; t++) begin
      if (fr[t] > fr[t-1]) begin
        etau = t - 1; ebeat = t;
        break;
      end
    end
    if (t0 == n - 1) begin etau = t0; ebeat = t0; end
    m_hold = etau;
  endfunction

  // gap_mode: 0 back-to-back, 1 about 1/3 duty, 2 random light gaps.
  // stop_at < n-1 abandons the frame early (no last beat, no expectation).
  task automatic run_frame(input int n, input int gap_mode, input int stop_at);
    int etau, evoiced, ebeat, gaps;
    bit scored;
    scored = (stop_at >= n - 1);
    if (scored) model(n, etau, evoiced, ebeat);
    for (int i = 0; i <= stop_at; i++) begin
      gaps = (gap_mode == 1) ? int'($urandom_range(0, 4)) :
             (gap_mode == 2) ? int'($urandom_range(0, 3) == 0) : 0;
      for (int g = 0; g < gaps; g++) begin
        @(posedge clk); #1;
        dvalid = 1'b0; dlast = 1'b0; diff = $urandom;
      end
      @(posedge clk); #1;
      dvalid = 1'b1;
      diff   = fr[i];
      dlast  = (i == n - 1);
      if (scored && i == ebeat) sbq.push_back('{etau, evoiced, cyc + 3});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      dvalid = 1'b0; dlast = 1'b0;
    end
  endtask

  task automatic fill_const(input int n, input int v);
    for (int t = 0; t < n; t++) fr[t] = 32'(v);
  endtask

  task automatic fill_voiced();
    fill_const(2048, 1000);
    fr[199] = 100; fr[200] = 50; fr[201] = 100;
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (tau_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("tau", int'(tau), e.tau);
        chk("voiced", int'(voiced), e.voiced);
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, p, k;
    repeat (3) @(negedge clk);
    chk("reset_tau", int'(tau), DEFAULT_TAU);
    chk("reset_valid", int'(tau_valid), 0);
    chk("reset_voiced", int'(voiced), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(3);

    // Silence after reset: default tau, unvoiced.
    fill_const(2048, 0);
    run_frame(2048, 0, 2047);
    // Voiced frame, dip ended by a rise (back-to-back with previous frame).
    fill_voiced();
    run_frame(2048, 0, 2047);
    // Silence re-emits the last voiced tau.
    fill_const(300, 0);
    run_frame(300, 0, 299);
    idle(2);
    // Dip running to frame end.
    fill_const(401, 1000);
    for (int t = 300; t <= 400; t++) fr[t] = 32'(400 - t);
    run_frame(401, 0, 400);
    // Gapped input, 1/3 duty.
    fill_voiced();
    run_frame(2048, 1, 2047);
    // MIN_TAU gating.
    fill_const(100, 1000);
    fr[5] = 0;
    run_frame(100, 0, 99);
    // Crossing on the final beat.
    fill_const(60, 1000);
    fr[59] = 10;
    run_frame(60, 2, 59);

    // Randomized frames.
    for (int f = 0; f < 14; f++) begin
      n = $urandom_range(25, 300);
      for (int t = 0; t < n; t++) fr[t] = $urandom_range(500, 5000);
      if (f % 4 != 3) begin
        p = $urandom_range(MIN_TAU, n - 1);
        k = $urandom_range(1, 12);
        for (int t = p; t < n && t < p + k; t++) fr[t] = $urandom_range(0, 60);
      end
      if (f == 5) fill_const(n, 0);
      run_frame(n, f % 3, n - 1);
    end
    idle(6);

    // Reset mid-frame inside a dip at t = 150.
    fill_const(2048, 1000);
    for (int t = 140; t <= 150; t++) fr[t] = 32'(200 - t);
    run_frame(2048, 0, 150);
    @(posedge clk); #1;
    dvalid = 1'b0; dlast = 1'b0;
    rst = 1'b1;
    m_hold = DEFAULT_TAU;
    repeat (2) @(negedge clk);
    chk("midreset_tau", int'(tau), DEFAULT_TAU);
    chk("midreset_valid", int'(tau_valid), 0);
    chk("midreset_voiced", int'(voiced), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(4);
    chk("post_reset_tau", int'(tau), DEFAULT_TAU);
    // Silence then a clean voiced frame after reset.
    fill_const(200, 0);
    run_frame(200, 0, 199);
    fill_voiced();
    run_frame(2048, 0, 2047);

    for (int i = 0; i < 20 && sbq.size() != 0; i++) idle(1);
    idle(4);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/yin_tau_picker.md
# yin_tau_picker

Pitch-period picker between the YIN difference-function engine and the PSOLA resynthesis stage. Per analysis frame it consumes the streamed difference values d(tau), tau = 0..MAX_TAU, and applies the cumulative-mean-normalized threshold test without a divider. It emits exactly one period estimate per frame as an 11-bit tau with a one-cycle valid pulse, matching the tau/valid input of the PSOLA stage. Unvoiced frames (no threshold crossing) re-emit the last voiced tau, so PSOLA always receives a usable period.

## Interface
- MAX_TAU, 2047: largest lag examined; must be < 2048, so tau fits in 11 bits.
- MIN_TAU, 20: smallest lag eligible as a candidate (rejects near-zero lags).
- THRESHOLD, 26: YIN threshold in Q0.8 (26/256 ≈ 0.10); range 1..255.
- DEFAULT_TAU, 100: tau re-emitted on unvoiced frames before any voiced frame.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset; asynchronous, active-high.
- diff_in  in  32  unsigned d(tau) for the current lag.
- diff_valid_in  in  1  diff_in valid this cycle. Arbitrary gaps are allowed; there is no backpressure.
- diff_last_in  in  1  qualifies the final beat of a frame; sampled only with diff_valid_in.
- tau_out  out  11  chosen period in samples.
- tau_valid_out  out  1  one-cycle pulse; exactly one per frame.
- voiced_out  out  1  qualified by tau_valid_out: 1 = threshold crossing found, 0 = fallback tau.

## Operation
- **Lag index.** Internal idx counts valid beats from 0 and saturates at MAX_TAU+1. Beats with idx > MAX_TAU are ignored except for their diff_last_in. idx and the running sum clear on the beat after a last beat.
- **Running sum.** S(t) = Σ d(j) for j = 1..t. Width is 43 bits unsigned and cannot overflow (2047·(2³²−1) < 2⁴³). d(0) is excluded.
- **Threshold test** (equivalent to d'(t) < THRESHOLD/256):
  - Condition: below = (d(t)·t·256 < THRESHOLD·S(t)), with t ≥ MIN_TAU.
  - Both sides are 51-bit unsigned and compared unsigned.
  - S = 0 (silence) makes below false.
- **Rising test.** rising = d(t) > d(t−1), using the raw previous beat's value. It is undefined for t = 0 and forced false there.
- **Pipeline.**
  - Stage 1 registers d·t, S, d_prev, idx and last.
  - Stage 2 registers the below, rising, idx and last flags.
  - The FSM acts on stage 2.
- **FSM states**, entered as SEARCH on reset:
  - SEARCH:
    - If below: go to DIP.
    - Else if last: emit (tau_hold, voiced=0) and stay in SEARCH.
  - DIP:
    - If rising: emit (idx−1, voiced=1), set tau_hold ← idx−1, go to FLUSH.
    - Else if last: emit (idx, voiced=1), set tau_hold ← idx, go to SEARCH.
  - FLUSH: ignore beats. On last, go to SEARCH with no second emit.
- **Same-beat rule.** If the beat that makes below true also carries last, emit (idx, voiced=1) and go to SEARCH.
- **Register values.**
  - tau_hold resets to DEFAULT_TAU.
  - tau_out holds its value between pulses.
  - voiced_out holds its value between pulses.

## Timing
- **Reset values:**
  - tau_out = DEFAULT_TAU.
  - tau_valid_out = 0.
  - voiced_out = 0.
  - FSM = SEARCH.
  - idx = 0, S = 0, pipeline valids = 0.
- **Reset mid-frame** clears everything. The first beat after reset is treated as tau = 0.
- **Latency.**
  - A beat sampled on clock edge E that triggers an emit asserts tau_valid_out from edge E+2 for exactly one cycle.
  - Back-to-back beats sustain 1 beat/cycle.
  - Gaps in diff_valid_in stall only idx/S updates; pipeline valids propagate independently.
- **Emit rate.** At most one emit per frame. A last beat arriving 1 cycle after a DIP emit must not produce a second pulse.
- **Consecutive frames** with no idle cycle between the last beat and the next tau = 0 beat are supported.

## Test plan
- **Voiced, dip ended by a rise.** Frame of 2048 beats with d = 1000 everywhere except d(200) = 50, d(199) = d(201) = 100. Required: one pulse 3 cycles after the beat t = 201, with tau_out = 200 and voiced_out = 1.
- **Silence.** All-zero frame after reset. Required: pulse 3 cycles after the last beat, with tau_out = 100 (DEFAULT_TAU) and voiced_out = 0. A following silent frame re-emits the prior voiced tau.
- **Dip running to frame end.** Monotonically decreasing d from t = 300 to the last beat at t = 400, with d' below threshold from 300. Required: tau_out = 400 and voiced_out = 1, one pulse only.
- **Gapped input.** Same stimulus as the first scenario with diff_valid_in at 1/3 duty and random gaps. Required: tau_out = 200, and the pulse lands 3 cycles after the t = 201 beat.
- **MIN_TAU gating.** Frame with d(5) = 0 and all other d = 1000. Required: no voiced detection; fallback tau with voiced_out = 0.
- **Reset mid-frame.** Assert rst_in mid-frame inside a dip at t = 150. Required: outputs return to their reset values with no pulse. The next clean frame behaves as in the first scenario.
